// File: rtl/eightbit_core.sv
// eightbit_core: multi-cycle RV32I core on a single unified memory port
module eightbit_core #(
  parameter int M_WIDTH = 32,
  parameter int REG_CNT = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic [M_WIDTH-1:0] addr,
  input  logic [M_WIDTH-1:0] data_in,
  output logic [M_WIDTH-1:0] data_out,
  output logic               we
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM_RD, MEM_WB, MERGE, MEM_WR} state_t;

  state_t             state, state_nxt;
  logic [M_WIDTH-1:0] pc, a, b;
  logic [31:0]        ir;
  logic [M_WIDTH-1:0] rf [REG_CNT];

  logic [6:0]         op;
  logic [2:0]         f3;
  logic [4:0]         rd, rs1_idx, rs2_idx;
  logic [M_WIDTH-1:0] rs1_val, rs2_val;
  logic [M_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [M_WIDTH-1:0] opb, alu, jalr_t, next_pc, exe_val, ld_val, ea, merged, pc4, rf_wd;
  logic [4:0]         shamt;
  logic               taken, mem_op, exe_wr, rf_we;

  assign op      = ir[6:0];
  assign f3      = ir[14:12];
  assign rd      = ir[11:7];
  // Source registers are read straight off the fetched word while IR is being loaded.
  assign rs1_idx = data_in[19:15];
  assign rs2_idx = data_in[24:20];
  assign rs1_val = int'(rs1_idx) < REG_CNT ? rf[rs1_idx] : '0;
  assign rs2_val = int'(rs2_idx) < REG_CNT ? rf[rs2_idx] : '0;

  assign imm_i = M_WIDTH'($signed(ir[31:20]));
  assign imm_s = M_WIDTH'($signed({ir[31:25], ir[11:7]}));
  assign imm_b = M_WIDTH'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
  assign imm_u = M_WIDTH'($signed({ir[31:12], 12'b0}));
  assign imm_j = M_WIDTH'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));

  assign pc4     = pc + M_WIDTH'(4);
  assign opb     = op == OP_REG ? b : imm_i;
  assign shamt   = opb[4:0];
  assign mem_op  = op == OP_LOAD || op == OP_STORE;
  assign exe_wr  = op == OP_LUI || op == OP_AUIPC || op == OP_JAL || op == OP_JALR ||
                   op == OP_IMM || op == OP_REG;
  assign ea      = a + (op == OP_STORE ? imm_s : imm_i);
  assign jalr_t  = a + imm_i;
  assign taken   = f3[2:1] == 2'b00 ? (a == b) ^ f3[0] :
                   f3[2:1] == 2'b10 ? ($signed(a) < $signed(b)) ^ f3[0] :
                   f3[2:1] == 2'b11 ? (a < b) ^ f3[0] : 1'b0;
  assign next_pc = op == OP_JAL ? pc + imm_j :
                   op == OP_JALR ? {jalr_t[M_WIDTH-1:1], 1'b0} :
                   (op == OP_BRANCH && taken) ? pc + imm_b : pc4;
  assign exe_val = op == OP_LUI ? imm_u :
                   op == OP_AUIPC ? pc + imm_u :
                   (op == OP_JAL || op == OP_JALR) ? pc4 : alu;
  assign ld_val  = f3[1:0] == 2'd0 ? (f3[2] ? M_WIDTH'(data_in[7:0]) : M_WIDTH'($signed(data_in[7:0]))) :
                   f3[1:0] == 2'd1 ? (f3[2] ? M_WIDTH'(data_in[15:0]) : M_WIDTH'($signed(data_in[15:0]))) :
                   data_in;
  // The word read at the store address keeps its upper bytes; only the low byte/half is replaced.
  assign merged  = f3[0] ? {data_in[M_WIDTH-1:16], b[15:0]} : {data_in[M_WIDTH-1:8], b[7:0]};
  assign rf_we   = (state == EXECUTE && exe_wr) || state == MEM_WB;
  assign rf_wd   = state == MEM_WB ? ld_val : exe_val;

  // Integer ALU shared by register-register and register-immediate forms.
  always_comb begin
    alu = a + opb;
    case (f3)
      3'd0: alu = (op == OP_REG && ir[30]) ? a - opb : a + opb;
      3'd1: alu = a << shamt;
      3'd2: alu = M_WIDTH'($signed(a) < $signed(opb));
      3'd3: alu = M_WIDTH'(a < opb);
      3'd4: alu = a ^ opb;
      3'd5: alu = ir[30] ? M_WIDTH'($signed(a) >>> shamt) : a >> shamt;
      3'd6: alu = a | opb;
      3'd7: alu = a & opb;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= state_nxt;
  end

  // Next-state sequencing; byte/half stores take a read-modify-write detour.
  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:   state_nxt = DECODE;
      DECODE:  state_nxt = EXECUTE;
      EXECUTE: state_nxt = op == OP_LOAD ? MEM_RD :
                           op == OP_STORE ? (f3 == 3'd2 ? MEM_WR : MEM_RD) : FETCH;
      MEM_RD:  state_nxt = op == OP_LOAD ? MEM_WB : MERGE;
      default: state_nxt = FETCH;
    endcase
  end

  // Memory port drive: pc for fetch, effective address for data phases.
  always_comb begin
    addr     = (state == MEM_RD || state == MERGE || state == MEM_WR) ? ea : pc;
    we       = state == MERGE || state == MEM_WR;
    data_out = state == MERGE ? merged : state == MEM_WR ? b : '0;
  end

  // Architectural state: pc, instruction, operand latches and register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= '0;
      ir <= '0;
      a  <= '0;
      b  <= '0;
      for (int i = 0; i < REG_CNT; i++) rf[i] <= '0;
    end else begin
      case (state)
        DECODE: begin
          ir <= data_in[31:0];
          a  <= rs1_val;
          b  <= rs2_val;
        end
        EXECUTE: if (!mem_op) pc <= next_pc;
        MEM_WB, MERGE, MEM_WR: pc <= pc4;
        default: ;
      endcase
      if (rf_we && rd != 5'd0 && int'(rd) < REG_CNT) rf[rd] <= rf_wd;
    end
  end
endmodule

// File: tb/tb_eightbit_core.sv
// tb_eightbit_core: directed program runs against a byte-array memory model
module tb_eightbit_core;
  logic        clk, rst, we, clr, ld_en;
  logic [31:0] addr, data_in, data_out, ld_data;
  logic [11:0] ld_addr;
  logic [7:0]  mem [4096];
  logic [31:0] prog [$];
  int          checks, failures;

  eightbit_core dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .data_out(data_out), .we(we)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else if (ld_en) begin
      mem[ld_addr]         <= ld_data[7:0];
      mem[ld_addr + 12'd1] <= ld_data[15:8];
      mem[ld_addr + 12'd2] <= ld_data[23:16];
      mem[ld_addr + 12'd3] <= ld_data[31:24];
    end else if (we) begin
      mem[addr[11:0]]         <= data_out[7:0];
      mem[addr[11:0] + 12'd1] <= data_out[15:8];
      mem[addr[11:0] + 12'd2] <= data_out[23:16];
      mem[addr[11:0] + 12'd3] <= data_out[31:24];
    end
    data_in <= {mem[addr[11:0] + 12'd3], mem[addr[11:0] + 12'd2], mem[addr[11:0] + 12'd1], mem[addr[11:0]]};
  end

  function automatic logic [31:0] peek(input logic [11:0] a);
    return {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
  endfunction

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction
  function automatic logic [31:0] enc_u(int imm, int rd, int op);
    return {imm[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return enc_i(imm, rs1, 0, rd, 'h13);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic boot;
    rst = 0;
    clr = 1;
    @(negedge clk);
    clr = 0;
    foreach (prog[i]) begin
      ld_addr = 12'(i * 4);
      ld_data = prog[i];
      ld_en   = 1;
      @(negedge clk);
    end
    ld_en = 0;
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1;
    @(negedge clk);
    ld_en = 0;
  endtask

  initial begin
    checks = 0; failures = 0; rst = 0; clr = 0; ld_en = 0; ld_addr = '0; ld_data = '0;

    prog = '{addi(10, 0, 5), addi(11, 10, -7), addi(0, 0, 1), enc_s('hE0, 10, 0, 2),
             enc_i('hE0, 0, 2, 12, 3), enc_j(0, 0)};
    boot();
    check("reset_addr", addr, 32'h0);
    check("reset_we", {31'b0, we}, 32'h0);
    check("reset_dout", data_out, 32'h0);
    rst = 1;
    #1 check("fetch0_addr", addr, 32'h0);
    cyc(3);
    check("fetch1_addr", addr, 32'h4);
    cyc(8);
    check("sw_exec_we", {31'b0, we}, 32'h0);
    rst = 0;
    #1 check("abort_addr", addr, 32'h0);
    check("abort_we", {31'b0, we}, 32'h0);
    cyc(2);
    check("abort_no_store", peek(12'hE0), 32'h0);
    rst = 1;
    cyc(11);
    check("sw_exec_we2", {31'b0, we}, 32'h0);
    cyc(1);
    check("sw_we", {31'b0, we}, 32'h1);
    check("sw_addr", addr, 32'hE0);
    check("sw_dout", data_out, 32'h5);
    cyc(1);
    check("sw_we_drop", {31'b0, we}, 32'h0);
    check("lw_fetch", addr, 32'h10);
    cyc(10);
    check("x10", dut.rf[10], 32'h5);
    check("x11", dut.rf[11], 32'hFFFFFFFE);
    check("x0", dut.rf[0], 32'h0);
    check("lw_x12", dut.rf[12], 32'h5);
    check("mem_e0", peek(12'hE0), 32'h5);

    prog = '{addi(10, 0, 'hAB), addi(5, 0, 'hE0), enc_s(1, 10, 5, 0), enc_i(1, 5, 0, 6, 3),
             enc_i(1, 5, 4, 7, 3), enc_i(0, 5, 1, 8, 3), enc_j(0, 0)};
    boot();
    poke(12'hE0, 32'h11223344);
    rst = 1;
    cyc(10);
    check("sb_we", {31'b0, we}, 32'h1);
    check("sb_addr", addr, 32'hE1);
    check("sb_merge", data_out, 32'h001122AB);
    cyc(20);
    check("sb_word", peek(12'hE0), 32'h1122AB44);
    check("sb_next_word", peek(12'hE4), 32'h0);
    check("lb", dut.rf[6], 32'hFFFFFFAB);
    check("lbu", dut.rf[7], 32'h000000AB);
    check("lh", dut.rf[8], 32'hFFFFAB44);

    prog = '{addi(2, 0, -1), addi(3, 0, 1), enc_b(8, 3, 2, 4), addi(20, 0, 1),
             enc_j(8, 1), addi(21, 0, 1), enc_b(8, 3, 2, 6), addi(22, 0, 7),
             enc_b(8, 3, 3, 0), addi(23, 0, 1), enc_b(8, 3, 2, 0), addi(24, 0, 9), enc_j(0, 0)};
    boot();
    rst = 1;
    cyc(9);
    check("blt_taken_fetch", addr, 32'h10);
    cyc(3);
    check("jal_fetch", addr, 32'h18);
    cyc(9);
    check("beq_taken_fetch", addr, 32'h28);
    cyc(11);
    check("jal_link", dut.rf[1], 32'h14);
    check("blt_skip", dut.rf[20], 32'h0);
    check("jal_skip", dut.rf[21], 32'h0);
    check("bltu_fall", dut.rf[22], 32'h7);
    check("beq_skip", dut.rf[23], 32'h0);
    check("beq_fall", dut.rf[24], 32'h9);

    prog = '{addi(1, 0, -16), addi(2, 0, 3), enc_r('h20, 1, 2, 0, 3), enc_r('h20, 2, 1, 5, 4),
             enc_r(0, 2, 1, 5, 5), enc_r(0, 2, 1, 2, 6), enc_r(0, 2, 1, 3, 7), enc_r(0, 2, 2, 1, 8),
             enc_r(0, 2, 1, 4, 9), enc_u('h12345, 10, 'h37), enc_u(1, 11, 'h17),
             enc_i('h35, 0, 0, 12, 'h67), addi(14, 0, 1), enc_i('h7F, 1, 7, 15, 'h13),
             enc_i('h100, 2, 6, 16, 'h13), enc_i('h402, 1, 5, 17, 'h13), enc_i(5, 2, 3, 18, 'h13),
             enc_j(0, 0)};
    boot();
    rst = 1;
    cyc(60);
    check("sub", dut.rf[3], 32'h13);
    check("sra", dut.rf[4], 32'hFFFFFFFE);
    check("srl", dut.rf[5], 32'h1FFFFFFE);
    check("slt", dut.rf[6], 32'h1);
    check("sltu", dut.rf[7], 32'h0);
    check("sll", dut.rf[8], 32'h18);
    check("xor", dut.rf[9], 32'hFFFFFFF3);
    check("lui", dut.rf[10], 32'h12345000);
    check("auipc", dut.rf[11], 32'h1028);
    check("jalr_link", dut.rf[12], 32'h30);
    check("jalr_skip", dut.rf[14], 32'h0);
    check("andi", dut.rf[15], 32'h70);
    check("ori", dut.rf[16], 32'h103);
    check("srai", dut.rf[17], 32'hFFFFFFFC);
    check("sltiu", dut.rf[18], 32'h1);

    prog = '{addi(10, 0, 0), addi(11, 0, 1), addi(5, 0, 1), addi(6, 0, 10),
             enc_s('hE0, 11, 0, 2), enc_b(24, 6, 5, 0), enc_r(0, 11, 10, 0, 7), addi(10, 11, 0),
             addi(11, 7, 0), addi(5, 5, 1), enc_j(-24, 0), enc_j(0, 0)};
    boot();
    rst = 1;
    cyc(400);
    check("fib_mem", peek(12'hE0), 32'h37);
    check("fib_a0", dut.rf[10], 32'd34);
    check("fib_a1", dut.rf[11], 32'd55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
